// File: rtl/enemy_wave_scheduler.sv
// enemy_wave_scheduler
//
// Owns the enemy slot pool of the playfield. Each slot cycles
// FREE -> SPAWN -> ALIVE -> HIT -> FREE. The block drives each plane's
// revive/boom controls, counts kills into a saturating score and picks
// which slot owns the current scan pixel.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   move_tick   one-clk pulse per movement step; paces all timers
//   game_run    spawning enabled while high
//   slot_exist  per slot: plane alive and not exploding
//   slot_en     per slot: opaque pixel at the scan position
//   hit         per slot: collision pulse (any length)
//   revive      per slot: return plane to spawn position (registered)
//   boom        per slot: explode/hide request (registered)
//   spawn_x     x coordinate latched at the last spawn (registered)
//   pix_valid   some slot owns the pixel (combinational)
//   pix_sel     lowest-index owning slot, 0 when none (combinational)
//   score       saturating kill count (registered)
//
// Build option:
//   ENEMY_SCHED_LFSR_EN  spawn_x taken from a 16-bit Fibonacci LFSR,
//                        folded into X_MIN..X_MIN+X_SPAN. Without it,
//                        spawn_x steps through low, middle and high edge.
//
// Slot states:
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_FREE  | slot in the pool, plane hidden (boom=1)
//   ST_SPAWN | revive held for 2 move ticks so the plane's boom clears
//   ST_ALIVE | plane flying; hit with slot_exist moves to ST_HIT
//   ST_HIT   | exploding (boom=1) for BOOM_TICKS move ticks

module enemy_wave_scheduler #(
    parameter int          SLOTS      = 4,
    parameter int          SPAWN_GAP  = 120,
    parameter int          BOOM_TICKS = 256,
    parameter int          X_MIN      = 0,
    parameter int          X_SPAN     = 190,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             move_tick,
    input  logic             game_run,
    input  logic [SLOTS-1:0] slot_exist,
    input  logic [SLOTS-1:0] slot_en,
    input  logic [SLOTS-1:0] hit,
    output logic [SLOTS-1:0] revive,
    output logic [SLOTS-1:0] boom,
    output logic [9:0]       spawn_x,
    output logic             pix_valid,
    output logic [2:0]       pix_sel,
    output logic [15:0]      score
);

    localparam int GW = $clog2(SPAWN_GAP);
    localparam int CW = (BOOM_TICKS > 2) ? $clog2(BOOM_TICKS) : 1;

    localparam logic [GW-1:0] GAP_LAST   = GW'(SPAWN_GAP - 1);
    localparam logic [CW-1:0] BOOM_LOAD  = CW'(BOOM_TICKS - 1);
    // SPAWN counts down 1 -> 0 -> ALIVE, i.e. exactly two move ticks.
    localparam logic [CW-1:0] SPAWN_LOAD = CW'(1);
    localparam logic [9:0]    X_LO       = 10'(X_MIN);

    localparam bit PARAMS_OK = (SLOTS >= 2) && (SLOTS <= 8) && (SPAWN_GAP >= 3) &&
                               (BOOM_TICKS >= 1) && (X_SPAN >= 128) && (X_SPAN <= 255) &&
                               (LFSR_SEED != 16'h0000);

    if (!PARAMS_OK) begin : g_param_check
        $error("enemy_wave_scheduler: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_SPAWN = 2'd1,
        ST_ALIVE = 2'd2,
        ST_HIT   = 2'd3
    } slot_state_e;

    slot_state_e       state_q [SLOTS];
    slot_state_e       state_d [SLOTS];
    logic [CW-1:0]     cnt_q   [SLOTS];
    logic [CW-1:0]     cnt_d   [SLOTS];

    logic [SLOTS-1:0]  revive_q, revive_d;
    logic [SLOTS-1:0]  boom_q,   boom_d;
    logic [GW-1:0]     gap_q,    gap_d;
    logic [15:0]       score_q,  score_d;
    logic [9:0]        spawn_x_q, spawn_x_d;

    logic [SLOTS-1:0]  free_vec;
    logic [SLOTS-1:0]  accept;
    logic              any_free;
    logic [2:0]        spawn_idx;
    logic              spawn_fire;
    logic [3:0]        hit_cnt;
    logic [16:0]       score_sum;
    logic [9:0]        x_next;

    // ------------------------------------------------------------------
    // Spawn x source
    // ------------------------------------------------------------------
`ifdef ENEMY_SCHED_LFSR_EN
    localparam logic [7:0] SPAN8 = 8'(X_SPAN);

    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  lfsr_v;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        lfsr_v = lfsr_q[7:0];
        // With X_SPAN >= 128 a single fold always lands inside the range.
        if (lfsr_v > SPAN8) begin
            lfsr_v = lfsr_v - SPAN8 - 8'd1;
        end
        x_next = X_LO + {2'b00, lfsr_v};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    localparam logic [9:0] X_MID = 10'(X_MIN + X_SPAN / 2);
    localparam logic [9:0] X_HI  = 10'(X_MIN + X_SPAN);

    logic [1:0] x_idx_q, x_idx_d;

    always_comb begin
        x_idx_d = x_idx_q;
        case (x_idx_q)
            2'd0:    x_next = X_LO;
            2'd1:    x_next = X_MID;
            default: x_next = X_HI;
        endcase
        if (spawn_fire) begin
            x_idx_d = (x_idx_q == 2'd2) ? 2'd0 : x_idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_idx_q <= 2'd0;
        end else begin
            x_idx_q <= x_idx_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Slot status, hit acceptance and spawn decision
    // ------------------------------------------------------------------
    always_comb begin
        free_vec  = '0;
        accept    = '0;
        spawn_idx = '0;
        hit_cnt   = '0;
        for (int i = 0; i < SLOTS; i++) begin
            free_vec[i] = (state_q[i] == ST_FREE);
            accept[i]   = (state_q[i] == ST_ALIVE) && hit[i] && slot_exist[i];
            hit_cnt     = hit_cnt + 4'(accept[i]);
        end
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                spawn_idx = 3'(i);
            end
        end
        any_free   = |free_vec;
        spawn_fire = move_tick && game_run && (gap_q == GAP_LAST) && any_free;
    end

    // ------------------------------------------------------------------
    // Per-slot FSM
    // ------------------------------------------------------------------
    always_comb begin
        revive_d = '0;
        boom_d   = '0;
        for (int i = 0; i < SLOTS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_FREE: begin
                    if (spawn_fire && (spawn_idx == 3'(i))) begin
                        state_d[i] = ST_SPAWN;
                        cnt_d[i]   = SPAWN_LOAD;
                    end
                end
                ST_SPAWN: begin
                    // Hits are not looked at until the slot is ALIVE.
                    if (move_tick) begin
                        if (cnt_q[i] == '0) begin
                            state_d[i] = ST_ALIVE;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CW'(1);
                        end
                    end
                end
                ST_ALIVE: begin
                    if (accept[i]) begin
                        state_d[i] = ST_HIT;
                        cnt_d[i]   = BOOM_LOAD;
                    end
                end
                ST_HIT: begin
                    if (move_tick) begin
                        if (cnt_q[i] == '0) begin
                            state_d[i] = ST_FREE;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CW'(1);
                        end
                    end
                end
                default: begin
                    state_d[i] = ST_FREE;
                end
            endcase
            revive_d[i] = (state_d[i] == ST_SPAWN);
            boom_d[i]   = (state_d[i] == ST_FREE) || (state_d[i] == ST_HIT);
        end
    end

    // ------------------------------------------------------------------
    // Gap counter, score, spawn_x
    // ------------------------------------------------------------------
    always_comb begin
        gap_d = gap_q;
        if (!game_run) begin
            gap_d = '0;
        end else if (move_tick) begin
            if (gap_q == GAP_LAST) begin
                // Saturate here until a slot frees up.
                if (any_free) begin
                    gap_d = '0;
                end
            end else begin
                gap_d = gap_q + GW'(1);
            end
        end

        score_sum = {1'b0, score_q} + 17'(hit_cnt);
        score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];

        spawn_x_d = spawn_fire ? x_next : spawn_x_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                state_q[i] <= ST_FREE;
                cnt_q[i]   <= '0;
            end
            revive_q  <= '0;
            boom_q    <= '1;
            gap_q     <= '0;
            score_q   <= '0;
            spawn_x_q <= X_LO;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            revive_q  <= revive_d;
            boom_q    <= boom_d;
            gap_q     <= gap_d;
            score_q   <= score_d;
            spawn_x_q <= spawn_x_d;
        end
    end

    assign revive  = revive_q;
    assign boom    = boom_q;
    assign score   = score_q;
    assign spawn_x = spawn_x_q;

    // ------------------------------------------------------------------
    // Pixel arbiter: lowest index wins
    // ------------------------------------------------------------------
    always_comb begin
        pix_valid = |slot_en;
        pix_sel   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (slot_en[i]) begin
                pix_sel = 3'(i);
            end
        end
    end

endmodule

// File: tb/tb_enemy_wave_scheduler.sv
module tb_enemy_wave_scheduler;

    localparam int SLOTS      = 4;
    localparam int SPAWN_GAP  = 120;
    localparam int BOOM_TICKS = 256;
    localparam int X_MIN      = 0;
    localparam int X_SPAN     = 190;

    localparam int M_FREE  = 0;
    localparam int M_SPAWN = 1;
    localparam int M_ALIVE = 2;
    localparam int M_HIT   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             move_tick;
    logic             game_run;
    logic [SLOTS-1:0] slot_exist;
    logic [SLOTS-1:0] slot_en;
    logic [SLOTS-1:0] hit;
    logic [SLOTS-1:0] revive;
    logic [SLOTS-1:0] boom;
    logic [9:0]       spawn_x;
    logic             pix_valid;
    logic [2:0]       pix_sel;
    logic [15:0]      score;

    enemy_wave_scheduler #(
        .SLOTS(SLOTS), .SPAWN_GAP(SPAWN_GAP), .BOOM_TICKS(BOOM_TICKS),
        .X_MIN(X_MIN), .X_SPAN(X_SPAN), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .move_tick(move_tick), .game_run(game_run),
        .slot_exist(slot_exist), .slot_en(slot_en), .hit(hit),
        .revive(revive), .boom(boom), .spawn_x(spawn_x),
        .pix_valid(pix_valid), .pix_sel(pix_sel), .score(score)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SLOTS-1:0] en;
        logic             valid;
        logic [2:0]       sel;
    } pix_vec_t;

    pix_vec_t pix_tab [8];

    int   n_checks = 0;
    int   n_errors = 0;
    int   tick_phase = 0;
    logic preload_score = 1'b0;

    // Reference model: slot lifecycle as plain integers and tick budgets.
    int m_state [SLOTS];
    int m_left  [SLOTS];
    int m_gap;
    int m_score;
    int m_xidx;
    int m_spawn_x;
`ifdef ENEMY_SCHED_LFSR_EN
    logic [15:0] m_lfsr;
`endif

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++) begin
            m_state[i] = M_FREE;
            m_left[i]  = 0;
        end
        m_gap     = 0;
        m_score   = 0;
        m_xidx    = 0;
        m_spawn_x = X_MIN;
`ifdef ENEMY_SCHED_LFSR_EN
        m_lfsr = 16'hACE1;
`endif
    endtask

    function automatic int model_next_x();
        int v;
`ifdef ENEMY_SCHED_LFSR_EN
        v = int'(m_lfsr[7:0]);
        if (v > X_SPAN) v = v - (X_SPAN + 1);
`else
        if (m_xidx == 0)      v = 0;
        else if (m_xidx == 1) v = X_SPAN / 2;
        else                  v = X_SPAN;
`endif
        return X_MIN + v;
    endfunction

    task automatic model_step();
        int old_state [SLOTS];
        int acc;
        int first_free;
        for (int i = 0; i < SLOTS; i++) old_state[i] = m_state[i];
        if (preload_score) m_score = 65534;
        acc = 0;
        for (int i = 0; i < SLOTS; i++) begin
            if (old_state[i] == M_ALIVE && hit[i] && slot_exist[i]) begin
                m_state[i] = M_HIT;
                m_left[i]  = BOOM_TICKS;
                acc++;
            end
        end
        if (move_tick) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (old_state[i] == M_SPAWN || old_state[i] == M_HIT) begin
                    m_left[i]--;
                    if (m_left[i] == 0)
                        m_state[i] = (old_state[i] == M_SPAWN) ? M_ALIVE : M_FREE;
                end
            end
            first_free = -1;
            for (int i = 0; i < SLOTS && first_free < 0; i++)
                if (old_state[i] == M_FREE) first_free = i;
            if (game_run) begin
                if (m_gap >= SPAWN_GAP - 1) begin
                    if (first_free >= 0) begin
                        m_state[first_free] = M_SPAWN;
                        m_left[first_free]  = 2;
                        m_spawn_x = model_next_x();
                        m_xidx    = (m_xidx + 1) % 3;
                        m_gap     = 0;
                    end
                end else begin
                    m_gap++;
                end
            end
        end
        if (!game_run) m_gap = 0;
        m_score = (m_score + acc > 65535) ? 65535 : m_score + acc;
`ifdef ENEMY_SCHED_LFSR_EN
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_pix(input logic [SLOTS-1:0] en);
        for (int i = 0; i < SLOTS; i++)
            if (en[i]) return {1'b1, 3'(i)};
        return 4'b0000;
    endfunction

    task automatic compare_all();
        logic [SLOTS-1:0] er, eb;
        for (int i = 0; i < SLOTS; i++) begin
            er[i] = (m_state[i] == M_SPAWN);
            eb[i] = (m_state[i] == M_FREE) || (m_state[i] == M_HIT);
        end
        check("outputs_vs_model", 64'({revive, boom, spawn_x, score}),
              64'({er, eb, 10'(m_spawn_x), 16'(m_score)}));
        check("pixel_vs_model", 64'({pix_valid, pix_sel}), 64'(exp_pix(slot_en)));
    endtask

    task automatic run_clk(input logic tk);
        move_tick = tk;
        @(posedge clk);
        #1;
        compare_all();
        hit       = '0;
        move_tick = 1'b0;
    endtask

    task automatic paced_step(output logic tk);
        tk = (tick_phase == 3);
        tick_phase = (tick_phase + 1) % 4;
        run_clk(tk);
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic tk;
        int   ticks, hold, s0;
        bit   found;
        logic [SLOTS-1:0] av;

        pix_tab[0] = '{4'b0110, 1'b1, 3'd1};
        pix_tab[1] = '{4'b0000, 1'b0, 3'd0};
        pix_tab[2] = '{4'b1000, 1'b1, 3'd3};
        pix_tab[3] = '{4'b1111, 1'b1, 3'd0};
        pix_tab[4] = '{4'b0100, 1'b1, 3'd2};
        pix_tab[5] = '{4'b1010, 1'b1, 3'd1};
        pix_tab[6] = '{4'b1100, 1'b1, 3'd2};
        pix_tab[7] = '{4'b0001, 1'b1, 3'd0};

        rst = 1'b1; move_tick = 0; game_run = 0;
        slot_exist = '0; slot_en = '0; hit = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_boom",    64'(boom),    64'(4'hF));
        check("reset_revive",  64'(revive),  64'(4'h0));
        check("reset_score",   64'(score),   64'(16'h0));
        check("reset_spawn_x", 64'(spawn_x), 64'(X_MIN));
        rst = 1'b0;
        run_clk(1'b0);

        // First spawn: revive[0] on the 120th tick, held for 2 ticks.
        game_run = 1'b1;
        ticks = 0; found = 0;
        for (int k = 0; k < 1000 && !found; k++) begin
            paced_step(tk);
            if (tk) ticks++;
            if (revive[0]) found = 1;
        end
        check("first_spawn_ticks", 64'(ticks), 64'(SPAWN_GAP));
        check("first_spawn_boom0", 64'(boom[0]), 64'(0));
        check("first_spawn_x_range", 64'(spawn_x <= 10'(X_MIN + X_SPAN)), 64'(1));
`ifndef ENEMY_SCHED_LFSR_EN
        check("first_spawn_x", 64'(spawn_x), 64'(X_MIN));
`endif
        hold = 0;
        for (int k = 0; k < 100 && revive[0]; k++) begin
            paced_step(tk);
            if (tk) hold++;
        end
        check("revive_hold_ticks", 64'(hold), 64'(2));

        // Single hit on slot 0 and a repeated hit during HIT.
        slot_exist = 4'hF;
        repeat (3) paced_step(tk);
        hit = 4'b0001;
        paced_step(tk);
        check("hit_boom0", 64'(boom[0]), 64'(1));
        check("hit_score", 64'(score),   64'(1));
        for (int k = 0; k < 20; k++) begin
            if (k == 10) hit = 4'b0001;
            paced_step(tk);
        end
        check("rehit_score", 64'(score), 64'(1));

        // Wait for all four slots ALIVE, then multi-hit.
        found = 0;
        for (int k = 0; k < 20000 && !found; k++) begin
            paced_step(tk);
            if (revive == '0 && boom == '0) found = 1;
        end
        check("all_alive_reached", 64'(found), 64'(1));
        s0 = int'(score);
        hit = 4'b1011;
        paced_step(tk);
        check("multi_hit_score", 64'(score), 64'(16'(s0 + 3)));
        check("multi_hit_boom",  64'(boom),  64'(4'b1011));

        // Pool exhausted: next spawn only on the tick after slot 0 frees.
        hit = 4'b0100;
        paced_step(tk);
        ticks = tk ? 1 : 0;
        check("all_busy_boom", 64'(boom), 64'(4'hF));
        for (int k = 0; k < 3000 && revive == '0; k++) begin
            paced_step(tk);
            if (tk) ticks++;
        end
        check("busy_spawn_ticks", 64'(ticks),  64'(BOOM_TICKS + 1));
        check("busy_spawn_slot",  64'(revive), 64'(4'b0001));

        // Pixel arbiter table.
        for (int i = 0; i < 8; i++) begin
            slot_en = pix_tab[i].en;
            #1;
            check("pix_table", 64'({pix_valid, pix_sel}), 64'({pix_tab[i].valid, pix_tab[i].sel}));
        end

        // Randomised traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            game_run   = ($urandom % 10) != 0;
            slot_exist = SLOTS'($urandom);
            slot_en    = SLOTS'($urandom);
            hit        = (($urandom % 6) == 0) ? SLOTS'($urandom) : '0;
            run_clk(($urandom % 3) == 0);
        end

        // Saturation from a preloaded score, then reset mid-HIT.
        game_run = 1'b1; slot_exist = 4'hF; slot_en = '0; hit = '0;
        found = 0;
        for (int k = 0; k < 20000 && !found; k++) begin
            paced_step(tk);
            if ($countones(~boom & ~revive) >= 2) found = 1;
        end
        check("two_alive_reached", 64'(found), 64'(1));
        av = ~boom & ~revive;
        force dut.score_q = 16'hFFFE;
        preload_score = 1'b1;
        paced_step(tk);
        release dut.score_q;
        preload_score = 1'b0;
        check("preload_score", 64'(score), 64'(16'hFFFE));
        hit = av;
        paced_step(tk);
        check("saturated_score", 64'(score), 64'(16'hFFFF));
        check("saturated_boom", 64'(boom & av), 64'(av));
        repeat (5) paced_step(tk);
        rst = 1'b1;
        #1;
        check("midrun_rst_boom",    64'(boom),    64'(4'hF));
        check("midrun_rst_revive",  64'(revive),  64'(4'h0));
        check("midrun_rst_score",   64'(score),   64'(16'h0));
        check("midrun_rst_spawn_x", 64'(spawn_x), 64'(X_MIN));
        run_clk(1'b1);
        rst = 1'b0;
        game_run = 1'b0;
        repeat (8) paced_step(tk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
